// File: rtl/stop_it_game.sv
// "Stop It" game controller: latches an LFSR target, shows it, runs a count and judges the stop press.
// Optional consecutive-win score counter is enabled with the STOP_IT_SCORE_EN macro.
module stop_it_game #(
  parameter int SHOW_CYCLES   = 8,
  parameter int TICK_CYCLES   = 4,
  parameter int RESULT_CYCLES = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic [4:0] rand_i,
  output logic       next_o,
  output logic [4:0] target_o,
  output logic [4:0] count_o,
  output logic       busy_o,
  output logic       win_o,
  output logic       lose_o,
  output logic [3:0] score_o
);

  localparam int MAX_A = (SHOW_CYCLES > TICK_CYCLES) ? SHOW_CYCLES : TICK_CYCLES;
  localparam int MAX_C = (MAX_A > RESULT_CYCLES) ? MAX_A : RESULT_CYCLES;
  localparam int TW    = $clog2(MAX_C + 1);

  localparam logic [TW-1:0] SHOW_LAST   = TW'(SHOW_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_CYCLES - 1);
  localparam logic [TW-1:0] RESULT_LAST = TW'(RESULT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, LOAD, SHOW, COUNT, WIN, LOSE} state_t;

  state_t        state;
  logic [TW-1:0] timer;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      timer    <= '0;
      next_o   <= 1'b0;
      target_o <= '0;
      count_o  <= '0;
      busy_o   <= 1'b0;
      win_o    <= 1'b0;
      lose_o   <= 1'b0;
    end else begin
      next_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            state  <= LOAD;
            next_o <= 1'b1;
            busy_o <= 1'b1;
          end
        end
        LOAD: begin
          target_o <= rand_i;
          count_o  <= '0;
          timer    <= '0;
          state    <= SHOW;
        end
        SHOW: begin
          if (timer == SHOW_LAST) begin
            timer <= '0;
            state <= COUNT;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        COUNT: begin
          // A stop press wins over a coinciding tick: the pre-tick value is judged and kept.
          if (stop_i) begin
            timer <= '0;
            if (count_o == target_o) begin
              state <= WIN;
              win_o <= 1'b1;
            end else begin
              state  <= LOSE;
              lose_o <= 1'b1;
            end
          end else if (timer == TICK_LAST) begin
            timer   <= '0;
            count_o <= count_o + 5'd1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WIN, LOSE: begin
          if (timer == RESULT_LAST) begin
            timer  <= '0;
            state  <= IDLE;
            busy_o <= 1'b0;
            win_o  <= 1'b0;
            lose_o <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef STOP_IT_SCORE_EN
  logic [3:0] score;

  // Updated on the same edge that enters WIN or LOSE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      score <= '0;
    end else if (state == COUNT && stop_i) begin
      if (count_o == target_o) begin
        if (score != 4'd15) score <= score + 4'd1;
      end else begin
        score <= '0;
      end
    end
  end

  assign score_o = score;
`else
  assign score_o = 4'd0;
`endif

endmodule

// File: tb/tb_stop_it_game.sv
// Randomised self-checking bench for stop_it_game against a cycle-level game model.
module tb_stop_it_game;
  localparam int S = 8;
  localparam int T = 4;
  localparam int R = 16;

  logic       clk = 1'b0;
  logic       rst, start, stop;
  logic [4:0] rnd;
  logic       next;
  logic [4:0] target, count;
  logic       busy, win, lose;
  logic [3:0] score;

  always #5 clk = ~clk;

  stop_it_game #(.SHOW_CYCLES(S), .TICK_CYCLES(T), .RESULT_CYCLES(R)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .rand_i(rnd),
    .next_o(next), .target_o(target), .count_o(count), .busy_o(busy),
    .win_o(win), .lose_o(lose), .score_o(score)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model: phase plus cycles spent in it; count derived arithmetically from time in COUNT.
  typedef enum int {P_IDLE, P_LOAD, P_SHOW, P_COUNT, P_WIN, P_LOSE} phase_t;
  phase_t     m_phase = P_IDLE;
  int         m_n = 0;
  logic [4:0] m_target = '0;
  logic [4:0] m_frozen = '0;
  int         m_score = 0;

  function automatic logic [4:0] exp_count();
    if (m_phase == P_COUNT) return 5'((m_n / T) % 32);
    return m_frozen;
  endfunction

  function automatic logic [3:0] exp_score();
`ifdef STOP_IT_SCORE_EN
    return 4'(m_score);
`else
    return 4'd0;
`endif
  endfunction

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_phase = P_IDLE; m_n = 0; m_target = '0; m_frozen = '0; m_score = 0;
    end else begin
      case (m_phase)
        P_IDLE: if (start) begin m_phase = P_LOAD; m_n = 0; end
        P_LOAD: begin m_target = rnd; m_frozen = '0; m_phase = P_SHOW; m_n = 0; end
        P_SHOW: if (m_n == S - 1) begin m_phase = P_COUNT; m_n = 0; end else m_n++;
        P_COUNT: begin
          if (stop) begin
            m_frozen = exp_count();
            m_n = 0;
            if (m_frozen == m_target) begin
              m_phase = P_WIN;
              if (m_score < 15) m_score++;
            end else begin
              m_phase = P_LOSE;
              m_score = 0;
            end
          end else m_n++;
        end
        default: if (m_n == R - 1) begin m_phase = P_IDLE; m_n = 0; end else m_n++;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [17:0] got, exp;
      got = {next, target, count, busy, win, lose, score};
      exp = {m_phase == P_LOAD, m_target, exp_count(), m_phase != P_IDLE,
             m_phase == P_WIN, m_phase == P_LOSE, exp_score()};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model_cmp t=%0t got{next,tgt,cnt,busy,win,lose,score}=%h required=%h",
                 $time, got, exp);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (m_phase != P_IDLE && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", int'(m_phase == P_IDLE), 1);
  endtask

  task automatic play(input logic [4:0] r, input logic [4:0] stop_at, input int min_n,
                      input bit at_tick, input bit poke_start);
    int  k;
    int  hold;
    bit  found;
    bit  won;
    wait_idle();
    @(negedge clk); rnd = r; start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("next_pulse", int'(next), 1);
    @(negedge clk); rnd = 5'($urandom);
    check("next_single", int'(next), 0);
    check("target_latched", int'(target), int'(r));
    k = 0; found = 1'b0;
    while (k < 600 && !found) begin
      if (m_phase == P_COUNT && m_n >= min_n && exp_count() == stop_at &&
          (!at_tick || (m_n % T) == T - 1)) begin
        found = 1'b1;
      end else begin
        stop = (m_phase == P_SHOW) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        k++;
      end
    end
    check("stop_window", int'(found), 1);
    if (!found) return;
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    won = (stop_at == r);
    check("win_flag", int'(win), int'(won));
    check("lose_flag", int'(lose), int'(!won));
    check("count_frozen", int'(count), int'(stop_at));
    hold = 1;
    for (int i = 0; i < 40 && busy; i++) begin
      start = (poke_start && i < 3);
      @(negedge clk);
      if (win || lose) hold++;
    end
    start = 1'b0;
    check("result_hold", hold, R);
    check("busy_after", int'(busy), 0);
    $display("game target=%0d stop_at=%0d tick=%0d won=%0d score=%0d", r, stop_at, at_tick, won, score);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; rnd = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", int'(busy), 0);
    check("reset_count", int'(count), 0);
    check("reset_score", int'(score), 0);
    rst = 1'b0;
    chk_en = 1'b1;

    play(5'd3, 5'd3, 0, 1'b0, 1'b0);
    play(5'd10, 5'd9, 0, 1'b0, 1'b1);
    play(5'd31, 5'd31, 33 * T, 1'b0, 1'b0);
    play(5'd6, 5'd6, 0, 1'b1, 1'b0);

    // Asynchronous reset in the middle of the count phase.
    wait_idle();
    @(negedge clk); rnd = 5'd20; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 100 && !(m_phase == P_COUNT && exp_count() >= 5'd2); k++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_count", int'(count), 0);
    check("midrst_target", int'(target), 0);
    check("midrst_flags", int'({next, win, lose}), 0);
    check("midrst_score", int'(score), 0);
    $display("game mid-count reset applied");
    @(negedge clk); rst = 1'b0;

    for (int g = 0; g < 17; g++) play(5'd0, 5'd0, 0, 1'b0, 1'b0);
`ifdef STOP_IT_SCORE_EN
    check("score_saturated", int'(score), 15);
`else
    check("score_tied_zero", int'(score), 0);
`endif
    play(5'd5, 5'd4, 0, 1'b0, 1'b0);
    check("score_after_loss", int'(score), 0);

    for (int g = 0; g < 25; g++) begin
      logic [4:0] r;
      logic [4:0] s;
      r = 5'($urandom);
      s = ($urandom_range(0, 1) == 1) ? r : 5'($urandom);
      play(r, s, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    wait_idle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
